// File: rtl/tetris_input_ctrl.sv
// -----------------------------------------------------------------------------
// tetris_input_ctrl
//   Turns the raw USB HID keycode word from the MicroBlaze GPIO into one-cycle
//   game action pulses for tetris_core. The action pulses are aligned to the
//   start of each vsync pulse. The block provides:
//     - key-to-action mapping and stability filtering
//     - one-shot rotate and hard drop
//     - DAS/ARR auto-repeat for left/right
//     - a periodic soft drop
//
// Ports:
//   Clk        in   pixel clock, the only clock
//   Reset      in   asynchronous, active-high reset
//   vsync      in   VGA vsync, synchronous to Clk
//   keycodes   in   four HID keycodes in bytes [7:0]..[31:24]; comes from
//                   another clock domain and is quasi-static
//   frame_tick out  one-cycle pulse at the start of each vsync pulse
//   move_left  out  action pulse, only ever high together with frame_tick
//   move_right out  action pulse, only ever high together with frame_tick
//   rotate     out  action pulse, only ever high together with frame_tick
//   soft_drop  out  action pulse, only ever high together with frame_tick
//   hard_drop  out  action pulse, only ever high together with frame_tick
//   held       out  filtered key levels {hard, soft, rot, right, left}
// -----------------------------------------------------------------------------
module tetris_input_ctrl #(
    parameter logic [7:0] KEY_LEFT      = 8'h04,
    parameter logic [7:0] KEY_RIGHT     = 8'h07,
    parameter logic [7:0] KEY_ROT       = 8'h1A,
    parameter logic [7:0] KEY_SOFT      = 8'h16,
    parameter logic [7:0] KEY_HARD      = 8'h2C,
    parameter int         DAS_FRAMES    = 10,
    parameter int         ARR_FRAMES    = 3,
    parameter int         SOFT_FRAMES   = 2,
    parameter bit         VS_ACTIVE_LOW = 1'b1
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        vsync,
    input  logic [31:0] keycodes,
    output logic        frame_tick,
    output logic        move_left,
    output logic        move_right,
    output logic        rotate,
    output logic        soft_drop,
    output logic        hard_drop,
    output logic [4:0]  held
);

    typedef enum logic [1:0] {S_IDLE, S_DELAY, S_REPEAT} dir_state_t;

    localparam logic [5:0] DAS_LAST  = 6'(DAS_FRAMES - 1);
    localparam logic [5:0] ARR_LAST  = 6'(ARR_FRAMES - 1);
    localparam logic [5:0] SOFT_LAST = 6'(SOFT_FRAMES - 1);

    // A zero code never matches, so empty keycode slots cannot trigger
    // anything.
    function automatic logic key_hit(input logic [31:0] w, input logic [7:0] code);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (code != 8'h00 && w[8*i +: 8] == code) hit = 1'b1;
        end
        return hit;
    endfunction

    // The frame counters stick at 63 rather than wrapping.
    function automatic logic [5:0] sat_inc(input logic [5:0] c);
        return (c == 6'd63) ? c : c + 6'd1;
    endfunction

    logic [31:0] r_kc_s1, r_kc_s2, r_kc_s3, r_kc_stable;
    logic [4:0]  r_held_d;
    logic        r_vs_q;
    logic        r_rot_flag, r_hard_flag;
    logic [5:0]  r_soft_cnt;
    dir_state_t  r_dir_state [2];
    logic [5:0]  r_dir_cnt   [2];
    logic [1:0]  r_dir_pulse;

    logic [4:0]  w_dec;
    logic        w_vs_act, w_vs_q_act, w_tick;
    logic        w_rot_rise, w_hard_rise, w_rot_fire, w_hard_fire, w_soft_fire;
    logic        w_both_lr;

    assign w_dec = {key_hit(r_kc_stable, KEY_HARD),
                    key_hit(r_kc_stable, KEY_SOFT),
                    key_hit(r_kc_stable, KEY_ROT),
                    key_hit(r_kc_stable, KEY_RIGHT),
                    key_hit(r_kc_stable, KEY_LEFT)};

    assign w_vs_act   = VS_ACTIVE_LOW ? ~vsync  : vsync;
    assign w_vs_q_act = VS_ACTIVE_LOW ? ~r_vs_q : r_vs_q;
    assign w_tick     = ~w_vs_q_act & w_vs_act;

    // The rising edge of a one-shot key is seen in the same cycle as the new
    // held level. A press that lands on a tick cycle therefore still fires on
    // that tick.
    assign w_rot_rise  = held[2] & ~r_held_d[2];
    assign w_hard_rise = held[4] & ~r_held_d[4];
    assign w_rot_fire  = r_rot_flag  | w_rot_rise;
    assign w_hard_fire = r_hard_flag | w_hard_rise;
    assign w_soft_fire = held[3] && (r_soft_cnt == 6'd0);
    assign w_both_lr   = held[0] & held[1];

    assign move_left  = r_dir_pulse[0];
    assign move_right = r_dir_pulse[1];

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_kc_s1     <= '0;
            r_kc_s2     <= '0;
            r_kc_s3     <= '0;
            r_kc_stable <= '0;
            held        <= '0;
            r_held_d    <= '0;
            r_vs_q      <= 1'b0;
            frame_tick  <= 1'b0;
            rotate      <= 1'b0;
            hard_drop   <= 1'b0;
            soft_drop   <= 1'b0;
            r_rot_flag  <= 1'b0;
            r_hard_flag <= 1'b0;
            r_soft_cnt  <= '0;
            r_dir_pulse <= '0;
            for (int d = 0; d < 2; d++) begin
                r_dir_state[d] <= S_IDLE;
                r_dir_cnt[d]   <= '0;
            end
        end else begin
            // Capture stage: double-register the cross-domain word. Only a
            // value seen on two consecutive samples is accepted.
            r_kc_s1 <= keycodes;
            r_kc_s2 <= r_kc_s1;
            r_kc_s3 <= r_kc_s2;
            if (r_kc_s2 == r_kc_s3) r_kc_stable <= r_kc_s2;
            held     <= w_dec;
            r_held_d <= held;

            // Frame stage
            r_vs_q     <= vsync;
            frame_tick <= w_tick;

            rotate      <= 1'b0;
            hard_drop   <= 1'b0;
            soft_drop   <= 1'b0;
            r_dir_pulse <= '0;

            // Action stage: every pulse is aligned with frame_tick.
            if (w_tick) begin
                rotate      <= w_rot_fire;
                hard_drop   <= w_hard_fire;
                soft_drop   <= w_soft_fire & ~w_hard_fire;
                r_rot_flag  <= 1'b0;
                r_hard_flag <= 1'b0;

                if (held[3]) r_soft_cnt <= (r_soft_cnt >= SOFT_LAST) ? 6'd0 : r_soft_cnt + 6'd1;
                else         r_soft_cnt <= '0;

                for (int d = 0; d < 2; d++) begin
                    if (!held[d] || w_both_lr) begin
                        r_dir_state[d] <= S_IDLE;
                        r_dir_cnt[d]   <= '0;
                    end else begin
                        case (r_dir_state[d])
                            S_IDLE: begin
                                r_dir_pulse[d] <= 1'b1;
                                r_dir_cnt[d]   <= '0;
                                r_dir_state[d] <= S_DELAY;
                            end
                            S_DELAY: begin
                                if (r_dir_cnt[d] == DAS_LAST) begin
                                    r_dir_pulse[d] <= 1'b1;
                                    r_dir_cnt[d]   <= '0;
                                    r_dir_state[d] <= S_REPEAT;
                                end else begin
                                    r_dir_cnt[d] <= sat_inc(r_dir_cnt[d]);
                                end
                            end
                            S_REPEAT: begin
                                if (r_dir_cnt[d] == ARR_LAST) begin
                                    r_dir_pulse[d] <= 1'b1;
                                    r_dir_cnt[d]   <= '0;
                                end else begin
                                    r_dir_cnt[d] <= sat_inc(r_dir_cnt[d]);
                                end
                            end
                            default: begin
                                r_dir_state[d] <= S_IDLE;
                                r_dir_cnt[d]   <= '0;
                            end
                        endcase
                    end
                end
            end else begin
                r_rot_flag  <= w_rot_fire;
                r_hard_flag <= w_hard_fire;
            end
        end
    end

endmodule

// File: tb/tb_tetris_input_ctrl.sv
// -----------------------------------------------------------------------------
// tb_tetris_input_ctrl
//   Directed bench for tetris_input_ctrl. Each table record is one frame:
//   keycodes are applied just after a tick, and then the action pulses and the
//   held levels are compared at the next frame_tick. Hand-written sequences
//   cover the following cases:
//     - mid-frame reset
//     - a rotate tap shorter than a frame
//     - a keycode word that toggles every cycle
// -----------------------------------------------------------------------------
module tb_tetris_input_ctrl;

    localparam int F = 200;  // cycles per frame

    logic        Clk = 1'b0;
    logic        Reset;
    logic        vsync;
    logic [31:0] keycodes;
    logic        frame_tick, move_left, move_right, rotate, soft_drop, hard_drop;
    logic [4:0]  held;

    int checks = 0;
    int errors = 0;
    int stray  = 0;

    typedef struct {
        logic [31:0] kc;
        logic [4:0]  act;   // {hard, soft, rot, right, left}
        logic [4:0]  hld;
    } vec_t;

    vec_t tbl[$];

    tetris_input_ctrl dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .vsync      (vsync),
        .keycodes   (keycodes),
        .frame_tick (frame_tick),
        .move_left  (move_left),
        .move_right (move_right),
        .rotate     (rotate),
        .soft_drop  (soft_drop),
        .hard_drop  (hard_drop),
        .held       (held)
    );

    always #5 Clk = ~Clk;

    // vsync: active low for the first 2 cycles of each frame
    initial begin
        vsync = 1'b1;
        forever begin
            for (int c = 0; c < F; c++) begin
                @(negedge Clk);
                vsync = (c < 2) ? 1'b0 : 1'b1;
            end
        end
    end

    function automatic logic [4:0] acts();
        return {hard_drop, soft_drop, rotate, move_right, move_left};
    endfunction

    // any action pulse outside a frame_tick cycle is illegal
    always @(negedge Clk) begin
        if (!Reset && !frame_tick && (acts() != 5'b0)) stray++;
    end

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic wait_tick();
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < 3*F; c++) begin
            @(negedge Clk);
            if (frame_tick) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL wait_tick: got no frame_tick expected one within %0d cycles", 3*F);
        end
    endtask

    task automatic add(input logic [31:0] kc, input logic [4:0] act, input logic [4:0] hld);
        vec_t v;
        v.kc  = kc;
        v.act = act;
        v.hld = hld;
        tbl.push_back(v);
    endtask

    task automatic run_vecs(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            keycodes = tbl[i].kc;
            wait_tick();
            check($sformatf("vec%0d act", i),  16'(acts()), 16'(tbl[i].act));
            check($sformatf("vec%0d held", i), 16'(held),   16'(tbl[i].hld));
        end
    endtask

    initial begin
        int n1;
        int ticks_seen;

        // ---- part 1 table ----
        for (int i = 0; i < 20; i++)   // DAS/ARR: pulses at 0,10,13,16,19
            add(32'h0000_0004, (i==0 || i==10 || i==13 || i==16 || i==19) ? 5'b00001 : 5'b0, 5'b00001);
        add(32'h0, 5'b0, 5'b0);
        for (int i = 0; i < 5; i++) add(32'h001A_0000, (i==0) ? 5'b00100 : 5'b0, 5'b00100);
        add(32'h0, 5'b0, 5'b0);
        add(32'h1A00_0000, 5'b00100, 5'b00100);   // second press, byte 3
        add(32'h1A00_0000, 5'b0,     5'b00100);
        add(32'h0, 5'b0, 5'b0);
        add(32'h0000_0704, 5'b0, 5'b00011);       // left+right: nothing
        add(32'h0000_0704, 5'b0, 5'b00011);
        for (int i = 0; i < 11; i++) add(32'h0000_0007, (i==0 || i==10) ? 5'b00010 : 5'b0, 5'b00010);
        add(32'h0, 5'b0, 5'b0);
        for (int i = 0; i < 4; i++) add(32'h0000_0016, (i==0 || i==2) ? 5'b01000 : 5'b0, 5'b01000);
        add(32'h0, 5'b0, 5'b0);
        n1 = tbl.size();
        // ---- part 2 table: hard+soft together ----
        for (int i = 0; i < 5; i++)
            add(32'h0000_2C16, (i==0) ? 5'b10000 : ((i==2 || i==4) ? 5'b01000 : 5'b0), 5'b11000);
        add(32'h0, 5'b0, 5'b0);

        // ---- reset state ----
        keycodes = 32'h0;
        Reset    = 1'b1;
        repeat (4) @(negedge Clk);
        #1 check("reset outputs", {5'b0, frame_tick, acts(), held}, 16'h0);
        Reset = 1'b0;
        wait_tick();

        run_vecs(0, n1);

        // ---- rotate tap shorter than a frame ----
        repeat (20) @(negedge Clk);
        keycodes = 32'h0000_001A;
        repeat (30) @(negedge Clk);
        keycodes = 32'h0;
        wait_tick();
        check("tap rot act",  16'(acts()), 16'(5'b00100));
        check("tap rot held", 16'(held),   16'h0);
        wait_tick();
        check("tap rot again", 16'(acts()), 16'h0);

        // ---- reset while move_left is in DELAY ----
        keycodes = 32'h0000_0004;
        wait_tick();
        check("rst pre first", 16'(acts()), 16'(5'b00001));
        wait_tick();
        check("rst pre delay", 16'(acts()), 16'h0);
        repeat (50) @(negedge Clk);
        Reset = 1'b1;
        #1 check("mid reset outputs", {5'b0, frame_tick, acts(), held}, 16'h0);
        repeat (5) @(negedge Clk);
        Reset = 1'b0;
        wait_tick();
        check("post rst fresh", 16'(acts()), 16'(5'b00001));
        wait_tick();
        check("post rst delay", 16'(acts()), 16'h0);
        keycodes = 32'h0;
        wait_tick();
        check("post rst release", 16'(acts()), 16'h0);

        // ---- keycodes toggling every cycle: never accepted ----
        ticks_seen = 0;
        for (int i = 0; i < F + 10; i++) begin
            @(negedge Clk);
            if (frame_tick) begin
                ticks_seen++;
                check("toggle act",  16'(acts()), 16'h0);
                check("toggle held", 16'(held),   16'h0);
            end
            keycodes = (i % 2) ? 32'h0000_0004 : 32'h0000_001A;
        end
        check("toggle tick seen", 16'(ticks_seen > 0), 16'h1);

        run_vecs(n1, tbl.size());

        check("stray pulses", 16'(stray), 16'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
